// File: rtl/spi_tx_scheduler.sv
// Two-requester byte scheduler: round-robin arbiter into a small FIFO, drained one byte
// per 4-phase req/ack handshake toward the SPI clock domain.
module spi_tx_scheduler #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     req0_stb,
  input  logic [7:0]               req0_data,
  output logic                     req0_ack,
  input  logic                     req1_stb,
  input  logic [7:0]               req1_data,
  output logic                     req1_ack,
  output logic                     handshake_req,
  input  logic                     handshake_ack,
  output logic [7:0]               handshake_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun,
  output logic [1:0]               o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_REQ, ST_DROP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_ack_meta;
  logic           r_ack_s;
  logic [1:0]     r_sync_vld;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [LW-1:0]  r_level;
  logic [7:0]     r_mem [DEPTH];
  logic           r_last_grant;
  logic           r_hs_req;
  logic [7:0]     r_hs_data;
  logic           r_underrun;
  logic           w_full;
  logic           w_empty;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_push;
  logic           w_pop;
  logic [7:0]     w_push_data;

  // Requester handshake: stb+data are held by the requester until ack; ack is high for
  // exactly the cycle in which the byte is written into the FIFO tail.
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!w_full) begin
      if (req0_stb && req1_stb) begin
        if (r_last_grant) w_grant0 = 1'b1;
        else              w_grant1 = 1'b1;
      end else if (req0_stb) begin
        w_grant0 = 1'b1;
      end else if (req1_stb) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_push      = w_grant0 | w_grant1;
  assign w_push_data = w_grant1 ? req1_data : req0_data;
  assign w_pop       = (r_state == ST_LOAD) && !w_empty;

  // r_sync_vld keeps IDLE from trusting ack_s until the synchronizer has refilled after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
      r_sync_vld <= 2'b00;
    end else begin
      r_ack_meta <= handshake_ack;
      r_ack_s    <= r_ack_meta;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_grant0) r_last_grant <= 1'b0;
      if (w_grant1) r_last_grant <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (en && !r_ack_s && r_sync_vld[1]) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_REQ;
      ST_REQ:  if (r_ack_s)  w_next = ST_DROP;
      ST_DROP: if (!r_ack_s) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hs_req   <= 1'b0;
      r_hs_data  <= 8'h00;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_hs_req   <= (w_next == ST_REQ);
      r_underrun <= (r_state == ST_LOAD) && w_empty;
      if (r_state == ST_LOAD) r_hs_data <= w_empty ? IDLE_BYTE : r_mem[r_rptr];
    end
  end

  assign req0_ack       = w_grant0;
  assign req1_ack       = w_grant1;
  assign handshake_req  = r_hs_req;
  assign handshake_data = r_hs_data;
  assign fifo_level     = r_level;
  assign underrun       = r_underrun;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Bench for spi_tx_scheduler: table-driven arbiter/FIFO vectors plus hand-written
// handshake sequences; a monitor scores every transmitted byte against exp_q.
module tb_spi_tx_scheduler;

  localparam int         DEPTH     = 4;
  localparam logic [7:0] IDLE_BYTE = 8'h00;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_REQ = 2'd2, S_DROP = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       req0_stb = 1'b0, req1_stb = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ack, req1_ack;
  logic       handshake_req;
  logic       handshake_ack;
  logic [7:0] handshake_data;
  logic [2:0] fifo_level;
  logic       underrun;
  logic [1:0] dbg_state;

  logic [2:0] ack_pipe = 3'b000;
  logic       ack_force = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_urun  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       stb0;
    logic [7:0] d0;
    logic       stb1;
    logic [7:0] d1;
    logic       ack0;
    logic       ack1;
    logic [2:0] level;
  } vec_t;

  vec_t vecs[7];

  spi_tx_scheduler #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE_BYTE)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_stb(req0_stb), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_stb(req1_stb), .req1_data(req1_data), .req1_ack(req1_ack),
    .handshake_req(handshake_req), .handshake_ack(handshake_ack),
    .handshake_data(handshake_data), .fifo_level(fifo_level),
    .underrun(underrun), .o_dbg_state(dbg_state)
  );

  // clock / reset block; SPI-side responder acks 3 clocks after req
  always #5 clk = ~clk;
  always @(posedge clk) ack_pipe <= {ack_pipe[1:0], handshake_req};
  assign handshake_ack = ack_force | ack_pipe[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic       mon_prev_req = 1'b0;
  logic       mon_held_vld = 1'b0;
  logic [7:0] mon_held = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      mon_prev_req = 1'b0;
      mon_held_vld = 1'b0;
    end else begin
      if (underrun) n_urun++;
      if (handshake_req && !mon_prev_req) begin
        logic [7:0] exp_b;
        logic       exp_u;
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          exp_u = 1'b0;
        end else begin
          exp_b = IDLE_BYTE;
          exp_u = 1'b1;
        end
        check("tx_byte", handshake_data, exp_b);
        check("underrun_on_load", underrun, exp_u);
        mon_held     = handshake_data;
        mon_held_vld = 1'b1;
      end else if (mon_held_vld && (handshake_req || dbg_state == S_DROP)) begin
        check("tx_data_stable", handshake_data, mon_held);
        check("underrun_one_cycle", underrun, 1'b0);
      end
      mon_prev_req = handshake_req;
    end
  end

  // driver tasks
  task automatic apply_vec(input vec_t v, input string tag);
    req0_stb = v.stb0; req0_data = v.d0;
    req1_stb = v.stb1; req1_data = v.d1;
    @(negedge clk);
    check({tag, "_ack0"}, req0_ack, v.ack0);
    check({tag, "_ack1"}, req1_ack, v.ack1);
    if (req0_ack) exp_q.push_back(req0_data);
    if (req1_ack) exp_q.push_back(req1_data);
    @(posedge clk); #1;
    check({tag, "_level"}, fifo_level, v.level);
    req0_stb = 1'b0;
    req1_stb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_req", handshake_req, 1'b0);
    check("rst_data", handshake_data, 8'h00);
    check("rst_underrun", underrun, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dbg_state == S_IDLE && !handshake_req) begin ok = 1'b1; break; end
    end
    check("wait_idle", ok, 1'b1);
  endtask

  task automatic wait_level0();
    logic ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fifo_level == 3'd0) begin ok = 1'b1; break; end
    end
    check("wait_level0", ok, 1'b1);
  endtask

  task automatic wait_state(input logic [1:0] st, input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dbg_state == st) begin ok = 1'b1; break; end
    end
    check(tag, ok, 1'b1);
  endtask

  initial begin
    vec_t v;
    int   bad;
    int   urun_base;
    int   last_id;
    int   n_acks;
    logic a0, a1;

    // stb0 d0 stb1 d1 | ack0 ack1 level_after (en=0, no pops; last_grant starts at 1)
    vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1};
    vecs[2] = '{1'b1, 8'hEE, 1'b1, 8'h11, 1'b0, 1'b1, 3'd2};
    vecs[3] = '{1'b1, 8'h22, 1'b1, 8'hEE, 1'b1, 1'b0, 3'd3};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 3'd4};
    vecs[5] = '{1'b1, 8'hEE, 1'b1, 8'hEE, 1'b0, 1'b0, 3'd4};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b0, 3'd4};

    do_reset();
    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // full FIFO: pop and req1 stb in the same cycle
    req1_stb = 1'b1; req1_data = 8'h44; en = 1'b1;
    wait_state(S_LOAD, "first_load");
    check("full_pop_req1_ack", req1_ack, 1'b0);
    en = 1'b0;
    @(posedge clk); #1;
    check("level_after_pop", fifo_level, 3'd3);
    @(negedge clk);
    check("req1_ack_after_pop", req1_ack, 1'b1);
    if (req1_ack) exp_q.push_back(req1_data);
    @(posedge clk); #1;
    check("level_refilled", fifo_level, 3'd4);
    req1_stb = 1'b0;
    wait_idle();

    // drain, then underrun handshakes on an empty FIFO
    en = 1'b1;
    wait_level0();
    urun_base = n_urun;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (fifo_level != 3'd0) bad++;
    end
    check("empty_level_stays0", bad, 0);
    check("underrun_pulses_ge3", (n_urun - urun_base) >= 3, 1'b1);
    en = 1'b0;
    wait_idle();
    check("drain_q_empty", exp_q.size(), 0);

    // two bytes via req0, drained in order
    do_reset();
    v = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1}; apply_vec(v, "p0");
    v = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2}; apply_vec(v, "p1");
    en = 1'b1;
    wait_level0();
    en = 1'b0;
    wait_idle();
    check("pair_q_empty", exp_q.size(), 0);

    // both requesters streaming from reset: strict alternation starting with req0
    rst = 1'b1; exp_q.delete();
    req0_stb = 1'b1; req0_data = 8'h50;
    req1_stb = 1'b1; req1_data = 8'h90;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    last_id = 1;
    n_acks = 0;
    repeat (120) begin
      @(negedge clk);
      a0 = req0_ack; a1 = req1_ack;
      if (a0 || a1) begin
        check("single_ack", a0 & a1, 1'b0);
        check("rr_order", a1 ? 1 : 0, 1 - last_id);
        last_id = a1 ? 1 : 0;
        exp_q.push_back(a1 ? req1_data : req0_data);
        n_acks++;
      end
      @(posedge clk); #1;
      if (a0) req0_data = req0_data + 8'd1;
      if (a1) req1_data = req1_data + 8'd1;
    end
    check("rr_ack_count_ge8", n_acks >= 8, 1'b1);
    req0_stb = 1'b0; req1_stb = 1'b0;
    wait_level0();
    en = 1'b0;
    wait_idle();
    check("rr_q_empty", exp_q.size(), 0);

    // reset in REQ with 3 bytes queued, released while ack is still high
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = '{1'b1, 8'hC0 + 8'(i), 1'b0, 8'h00, 1'b1, 1'b0, 3'(i + 1)};
      apply_vec(v, $sformatf("q%0d", i));
    end
    en = 1'b1;
    wait_state(S_REQ, "reached_req");
    en = 1'b0;
    check("req_level3", fifo_level, 3'd3);
    rst = 1'b1;
    #1;
    check("midrst_req", handshake_req, 1'b0);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_state", dbg_state, S_IDLE);
    exp_q.delete();
    ack_force = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (dbg_state != S_IDLE) bad++;
    end
    check("idle_while_ack_high", bad, 0);
    ack_force = 1'b0;
    wait_state(S_LOAD, "load_after_ack_low");
    en = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
